// File: rtl/fpmul_arbiter.sv
// Round-robin front end sharing one FPMul core between NREQ requesters.
// Grants one requester, issues a start pulse, waits for done (or watchdog) and returns the result.
module fpmul_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 64,
    parameter int CW      = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0][31:0] opa,
    input  logic [NREQ-1:0][31:0] opb,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       rsp_valid,
    output logic                  rsp_err,
    output logic [31:0]           rsp_p,
    output logic [5:0]            rsp_flags,
    output logic                  fpm_start,
    output logic [31:0]           fpm_opa,
    output logic [31:0]           fpm_opb,
    input  logic                  fpm_done,
    input  logic [31:0]           fpm_p,
    input  logic [5:0]            fpm_flags,
    output logic                  busy,
    output logic                  timeout_sticky
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t        state;
    logic [PW-1:0] ptr, gidx, pick;
    logic          found;
    logic [CW-1:0] cnt;

    // Scan from the highest offset down so the nearest set bit at or after ptr wins.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % NREQ]) begin
                pick  = PW'((int'(ptr) + i) % NREQ);
                found = 1'b1;
            end
        end
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            ptr            <= '0;
            gidx           <= '0;
            cnt            <= '0;
            gnt            <= '0;
            rsp_valid      <= '0;
            rsp_err        <= 1'b0;
            rsp_p          <= '0;
            rsp_flags      <= '0;
            fpm_start      <= 1'b0;
            fpm_opa        <= '0;
            fpm_opb        <= '0;
            timeout_sticky <= 1'b0;
        end else begin
            fpm_start <= 1'b0;
            rsp_valid <= '0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        gnt       <= '0;
                        gnt[pick] <= 1'b1;
                        gidx      <= pick;
                        fpm_opa   <= opa[pick];
                        fpm_opb   <= opb[pick];
                        fpm_start <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // done takes priority over a watchdog expiry in the same cycle
                    if (fpm_done) begin
                        rsp_p           <= fpm_p;
                        rsp_flags       <= fpm_flags;
                        rsp_err         <= 1'b0;
                        rsp_valid[gidx] <= 1'b1;
                        state           <= S_RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        rsp_p           <= '0;
                        rsp_flags       <= '0;
                        rsp_err         <= 1'b1;
                        timeout_sticky  <= 1'b1;
                        rsp_valid[gidx] <= 1'b1;
                        state           <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    gnt   <= '0;
                    ptr   <= (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpmul_arbiter.sv
// Directed bench for fpmul_arbiter with a behavioural FPMul stand-in (fixed result table, programmable latency).
module tb_fpmul_arbiter;
    localparam int NREQ = 2, TIMEOUT = 8, CW = 4;

    logic                  clk = 1'b0, rst = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ-1:0][31:0] opa = '0, opb = '0;
    logic [NREQ-1:0]       gnt, rsp_valid;
    logic                  rsp_err, fpm_start, fpm_done, busy, timeout_sticky;
    logic [31:0]           rsp_p, fpm_opa, fpm_opb;
    logic [31:0]           fpm_p = '0;
    logic [5:0]            rsp_flags;
    logic [5:0]            fpm_flags = '0;
    logic                  mdl_done = 1'b0, stale_done = 1'b0;

    int checks = 0, errors = 0, cyc = 0, starts = 0;
    int mdl_k = 4, mdl_cnt = 0;
    bit mdl_hang = 1'b0;

    assign fpm_done = mdl_done | stale_done;

    fpmul_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk(clk), .rst(rst), .req(req), .opa(opa), .opb(opb), .gnt(gnt),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_p(rsp_p), .rsp_flags(rsp_flags),
        .fpm_start(fpm_start), .fpm_opa(fpm_opa), .fpm_opb(fpm_opb), .fpm_done(fpm_done),
        .fpm_p(fpm_p), .fpm_flags(fpm_flags), .busy(busy), .timeout_sticky(timeout_sticky)
    );

    always #5 clk = ~clk;

    // Hand-computed IEEE-754 products for the vectors used below.
    function automatic logic [37:0] fmul(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h40000000, 32'h40400000}: return {6'b000000, 32'h40C00000};
            {32'h3FC00000, 32'h40000000}: return {6'b000000, 32'h40400000};
            {32'h40800000, 32'h3F000000}: return {6'b000000, 32'h40000000};
            {32'h7F800000, 32'h00000000}: return {6'b001000, 32'h7FC00000};
            default:                      return {6'b000001, 32'h00000000};
        endcase
    endfunction

    // done is raised so that it is sampled k+2 edges after the grant edge
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        mdl_done <= 1'b0;
        if (fpm_start) begin
            starts                <= starts + 1;
            mdl_cnt               <= mdl_hang ? 0 : mdl_k;
            {fpm_flags, fpm_p}    <= fmul(fpm_opa, fpm_opb);
        end else if (mdl_cnt > 0) begin
            mdl_cnt <= mdl_cnt - 1;
            if (mdl_cnt == 1) mdl_done <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_nz(input bit on_rsp);
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if ((on_rsp ? rsp_valid : gnt) != '0) return;
        end
    endtask

    task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                          input int k, input bit hang, input logic [31:0] ep,
                          input logic [5:0] ef, input bit eerr, input int elat);
        int g_cyc, st0;
        mdl_k    = k;
        mdl_hang = hang;
        opa[idx] = a;
        opb[idx] = b;
        req[idx] = 1'b1;
        st0      = starts;
        wait_nz(1'b0);
        chk("grant", 32'(gnt), 32'(1) << idx);
        g_cyc = cyc;
        // operands are only sampled on the grant edge
        opa[idx] = 32'hDEADBEEF;
        opb[idx] = 32'h12345678;
        wait_nz(1'b1);
        req[idx] = 1'b0;
        chk("rsp_valid", 32'(rsp_valid), 32'(1) << idx);
        chk("latency", 32'(cyc - g_cyc), 32'(elat));
        chk("gnt_in_resp", 32'(gnt), 32'(1) << idx);
        chk("rsp_p", rsp_p, ep);
        chk("rsp_flags", 32'(rsp_flags), 32'(ef));
        chk("rsp_err", 32'(rsp_err), 32'(eerr));
        chk("start_pulses", 32'(starts - st0), 32'd1);
        @(negedge clk);
        chk("idle_after", 32'({busy, gnt, rsp_valid}), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rv", 32'(rsp_valid), 32'd0);
        chk("rst_start", 32'(fpm_start), 32'd0);
        chk("rst_opa", fpm_opa, 32'd0);
        chk("rst_opb", fpm_opb, 32'd0);
        chk("rst_p", rsp_p, 32'd0);
        chk("rst_misc", 32'({rsp_flags, rsp_err, timeout_sticky}), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // 2.0 * 3.0, done 4 cycles after start
        run_op(0, 32'h40000000, 32'h40400000, 4, 1'b0, 32'h40C00000, 6'b000000, 1'b0, 6);
        // Inf * 0 -> NaN, flags passed through
        run_op(1, 32'h7F800000, 32'h00000000, 3, 1'b0, 32'h7FC00000, 6'b001000, 1'b0, 5);
        // done on the same cycle the watchdog expires
        run_op(0, 32'h40800000, 32'h3F000000, 7, 1'b0, 32'h40000000, 6'b000000, 1'b0, 9);
        chk("sticky_clear", 32'(timeout_sticky), 32'd0);
        // hung multiply
        run_op(1, 32'h40000000, 32'h40400000, 0, 1'b1, 32'h0, 6'b000000, 1'b1, 9);
        chk("sticky_set", 32'(timeout_sticky), 32'd1);
        stale_done = 1'b1;
        repeat (2) @(negedge clk);
        stale_done = 1'b0;
        @(negedge clk);
        chk("stale_ignored", 32'({busy, gnt, fpm_start}), 32'd0);
        run_op(0, 32'h3FC00000, 32'h40000000, 2, 1'b0, 32'h40400000, 6'b000000, 1'b0, 4);
        chk("sticky_hold", 32'(timeout_sticky), 32'd1);

        // async reset while in WAIT
        mdl_hang = 1'b1;
        req[0]   = 1'b1;
        wait_nz(1'b0);
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_out", 32'({busy, gnt, fpm_start, timeout_sticky}), 32'd0);
        req[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_op(1, 32'h40000000, 32'h40400000, 4, 1'b0, 32'h40C00000, 6'b000000, 1'b0, 6);

        // contention: both requesting from reset
        rst = 1'b0;
        mdl_hang = 1'b0;
        mdl_k    = 2;
        opa[0] = 32'h40000000; opb[0] = 32'h40400000;
        opa[1] = 32'h3FC00000; opb[1] = 32'h40000000;
        req    = 2'b11;
        @(negedge clk);
        rst = 1'b1;
        for (int t = 0; t < 4; t++) begin
            wait_nz(1'b0);
            chk("cont_gnt", 32'(gnt), 32'(1) << (t % 2));
            wait_nz(1'b1);
            chk("cont_rv", 32'(rsp_valid), 32'(1) << (t % 2));
            chk("cont_p", rsp_p, (t % 2) ? 32'h40400000 : 32'h40C00000);
        end
        req = '0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpmul_arbiter.md
Name: fpmul_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one FPMul core between NREQ independent requesters.
- Each requester presents operands with a level request and receives a registered product, flags and a one-cycle response strobe.
- Generates the single-cycle start pulse to FPMul, waits for its done, latches results and routes them back.
- Includes a watchdog so a hung multiply cannot lock out the other requesters.

Parameters:
- NREQ, 2, number of requesters (2..8).
- TIMEOUT, 64, cycles to wait in WAIT for fpm_done before aborting (≥2).
- CW, 7, watchdog counter width; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester level request; held until that requester's rsp_valid.
- opa  in  32*NREQ  operand A, requester i at bits [32i+31:32i].
- opb  in  32*NREQ  operand B, same packing.
- gnt  out  NREQ  one-hot; bit i high from grant through the RESP cycle.
- rsp_valid  out  NREQ  one-cycle strobe per requester, asserted in RESP.
- rsp_err  out  1  qualifies rsp_valid; 1 = watchdog abort.
- rsp_p  out  32  latched product, shared by all requesters.
- rsp_flags  out  6  latched {OF,UF,NANF,INFF,DNF,ZF}.
- fpm_start  out  1  single-cycle start to FPMul.
- fpm_opa  out  32  registered operand A to FPMul.
- fpm_opb  out  32  registered operand B to FPMul.
- fpm_done  in  1  FPMul completion.
- fpm_p  in  32  FPMul product.
- fpm_flags  in  6  FPMul flags {OF,UF,NANF,INFF,DNF,ZF}.
- busy  out  1  high in any state other than IDLE.
- timeout_sticky  out  1  set on any watchdog abort; cleared only by reset.

Behaviour:
- Reset (rst=0, async): state=IDLE; ptr=0; all outputs 0; gnt=0; fpm_opa, fpm_opb, rsp_p, rsp_flags=0; watchdog counter=0.
- IDLE: if any req bit is set, grant the first set bit searching from ptr upward with wrap. On that edge:
  - register gnt (one-hot);
  - latch that requester's opa/opb into fpm_opa/fpm_opb;
  - go to ISSUE.
- If no req is set, stay in IDLE. fpm_done is ignored here (stale done from an aborted op).
- ISSUE (1 cycle): fpm_start=1, clear the watchdog counter, go to WAIT. fpm_done is ignored in ISSUE.
- WAIT:
  - fpm_start=0.
  - If fpm_done=1: latch fpm_p and fpm_flags into rsp_p/rsp_flags, set rsp_err=0, go to RESP.
  - Else if counter==TIMEOUT-1: set rsp_p=0, rsp_flags=0, rsp_err=1, timeout_sticky=1, go to RESP.
  - Else increment the counter.
- RESP (1 cycle):
  - rsp_valid[g]=1 for granted index g; gnt stays set.
  - Next state is IDLE, with gnt=0, rsp_valid=0 and ptr=(g+1) mod NREQ.
  - rsp_p, rsp_flags and rsp_err hold until the next RESP.
- Latency from req sampled in IDLE to rsp_valid: 2 + (cycles in WAIT) + 1. With a done arriving k cycles after start, rsp_valid appears k+2 cycles after the grant edge.
- Fairness: a requester waits at most NREQ-1 other transactions.
- Requester obligations:
  - Operands are sampled only on the grant edge; later changes have no effect.
  - Dropping req after the grant has no effect; the transaction completes.
  - Dropping req before the grant withdraws the request.
- Simultaneous fpm_done and timeout in the same WAIT cycle: done wins, rsp_err=0.
- A requester re-asserting req in its own RESP cycle is eligible in the next IDLE. ptr has already moved past it, so other pending requesters go first.
- The block has no back-pressure; the requester must accept rsp_valid.
- Reset mid-operation: state returns to IDLE immediately. A subsequent stale fpm_done is ignored by the IDLE/ISSUE rules.

Test Plan:
- Single op, NREQ=2: req[0]=1, opa0=0x40000000 (2.0), opb0=0x40400000 (3.0); model returns done 4 cycles after start → one fpm_start pulse, rsp_valid[0] exactly 6 cycles after the grant, rsp_p=0x40C00000, rsp_flags=0, rsp_err=0.
- Contention: req=2'b11 held from reset → grants alternate 0,1,0,1; every gnt is one-hot; each requester receives the product of its own operands.
- Watchdog: model never asserts done, TIMEOUT=8 → rsp_valid with rsp_err=1 and rsp_p=0 after 8 WAIT cycles; timeout_sticky=1. A stale done arriving later in IDLE is ignored, and the next op completes normally.
- Done/timeout collision: done asserted on the cycle the counter hits TIMEOUT-1 → rsp_err=0 and rsp_p equals the model result.
- Async reset mid-WAIT: pull rst low between edges → busy=0, gnt=0, fpm_start=0 immediately; after release, a fresh req completes correctly.
- Operand stability and flags: change opa0 after the grant → result uses the sampled value. Inputs 0x7F800000 × 0x00000000 → rsp_flags NANF bit set, passed through unchanged.
